// File: rtl/key_color_plotter.sv
// rtl/key_color_plotter.sv - PS/2 key-selected colour plotter with vblank-synchronised colour commit
// Decodes set-2 make/break/extended sequences; the colour change lands only at the start of vertical blanking.
module key_color_plotter #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          CNT_W      = 10,
  parameter int          COLOR_BITS = 4,
  parameter logic [7:0]  KEY_R      = 8'h2D,
  parameter logic [7:0]  KEY_G      = 8'h34,
  parameter logic [7:0]  KEY_B      = 8'h32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT_W-1:0]      rows,
  input  logic [CNT_W-1:0]      columns,
  input  logic [7:0]            code,
  input  logic                  code_valid,
  output logic [COLOR_BITS-1:0] data_red,
  output logic [COLOR_BITS-1:0] data_green,
  output logic [COLOR_BITS-1:0] data_blue,
  output logic [1:0]            active_key
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic [CNT_W-1:0]      H_LIM = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]      V_LIM = CNT_W'(V_ACTIVE);
  localparam logic [COLOR_BITS-1:0] ONES  = {COLOR_BITS{1'b1}};

  state_t     state, state_next;
  logic [1:0] pending, pending_next;
  logic [1:0] committed;
  logic       vblank_start;
  logic       blank;
  logic       release_match;

  assign vblank_start = (rows == V_LIM) && (columns == '0);
  assign blank        = (rows >= V_LIM) || (columns >= H_LIM);
  assign active_key   = committed;

  // A break only clears the selection when it releases the key that set it.
  assign release_match = ((pending == 2'd1) && (code == KEY_R)) ||
                         ((pending == 2'd2) && (code == KEY_G)) ||
                         ((pending == 2'd3) && (code == KEY_B));

  always_comb begin
    state_next   = state;
    pending_next = pending;
    if (code_valid) begin
      case (state)
        IDLE: begin
          if (code == 8'hF0)      state_next   = BRK;
          else if (code == 8'hE0) state_next   = EXT;
          else if (code == KEY_R) pending_next = 2'd1;
          else if (code == KEY_G) pending_next = 2'd2;
          else if (code == KEY_B) pending_next = 2'd3;
        end
        BRK: begin
          if (release_match) pending_next = 2'd0;
          state_next = IDLE;
        end
        EXT:     state_next = (code == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= 2'd0;
      committed <= 2'd0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      // Old pending value commits when a write coincides with the commit cycle.
      if (vblank_start) committed <= pending;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_red   <= '0;
      data_green <= '0;
      data_blue  <= '0;
    end else if (blank) begin
      data_red   <= '0;
      data_green <= '0;
      data_blue  <= '0;
    end else begin
      case (committed)
        2'd1: begin
          data_red   <= ONES;
          data_green <= '0;
          data_blue  <= '0;
        end
        2'd2: begin
          data_red   <= '0;
          data_green <= ONES;
          data_blue  <= '0;
        end
        2'd3: begin
          data_red   <= '0;
          data_green <= '0;
          data_blue  <= ONES;
        end
        default: begin
          data_red   <= ONES;
          data_green <= ONES;
          data_blue  <= ONES;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_color_plotter.sv
// tb/tb_key_color_plotter.sv - directed self-checking bench for key_color_plotter
module tb_key_color_plotter;

  logic       clk;
  logic       rst_n;
  logic [9:0] rows;
  logic [9:0] columns;
  logic [7:0] code;
  logic       code_valid;
  logic [3:0] data_red;
  logic [3:0] data_green;
  logic [3:0] data_blue;
  logic [1:0] active_key;

  int n_checks = 0;
  int n_fail   = 0;

  key_color_plotter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rows       (rows),
    .columns    (columns),
    .code       (code),
    .code_valid (code_valid),
    .data_red   (data_red),
    .data_green (data_green),
    .data_blue  (data_blue),
    .active_key (active_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    check({tag, "_red"}, data_red, r);
    check({tag, "_green"}, data_green, g);
    check({tag, "_blue"}, data_blue, b);
  endtask

  task automatic check_key(input string tag, input logic [1:0] exp);
    check(tag, {2'b00, active_key}, {2'b00, exp});
  endtask

  task automatic send(input logic [7:0] c);
    code       = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    code       = 8'h00;
  endtask

  // Start-of-vblank cycle followed by the first pixel of the next frame.
  task automatic commit_frame();
    rows    = 10'd480;
    columns = 10'd0;
    tick();
    rows    = 10'd0;
    columns = 10'd0;
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    rows       = 10'd0;
    columns    = 10'd0;
    code       = 8'h00;
    code_valid = 1'b0;

    #3;
    check_rgb("reset", 4'h0, 4'h0, 4'h0);
    check_key("reset_key", 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_rgb("white_after_reset", 4'hF, 4'hF, 4'hF);

    rows    = 10'd100;
    columns = 10'd5;
    send(8'h2D);
    check_key("red_pending_only", 2'd0);
    check_rgb("still_white_midframe", 4'hF, 4'hF, 4'hF);
    rows    = 10'd480;
    columns = 10'd0;
    tick();
    check_key("red_committed", 2'd1);
    check_rgb("vblank_black", 4'h0, 4'h0, 4'h0);
    rows = 10'd0;
    tick();
    check_rgb("red_pixels", 4'hF, 4'h0, 4'h0);

    send(8'hF0);
    send(8'h2D);
    commit_frame();
    check_key("red_released", 2'd0);
    check_rgb("white_after_release", 4'hF, 4'hF, 4'hF);

    send(8'h34);
    send(8'hF0);
    send(8'h2D);
    commit_frame();
    check_key("green_kept_on_other_break", 2'd2);
    check_rgb("green_pixels", 4'h0, 4'hF, 4'h0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send(8'hE0);
    send(8'h34);
    send(8'hE0);
    send(8'hF0);
    send(8'h32);
    commit_frame();
    check_key("extended_ignored", 2'd0);

    send(8'h32);
    commit_frame();
    check_key("blue_committed", 2'd3);
    rows    = 10'd10;
    columns = 10'd639;
    tick();
    check_rgb("last_visible_col", 4'h0, 4'h0, 4'hF);
    columns = 10'd640;
    tick();
    check_rgb("first_hblank_col", 4'h0, 4'h0, 4'h0);
    rows    = 10'd480;
    columns = 10'd100;
    tick();
    check_rgb("vblank_row", 4'h0, 4'h0, 4'h0);
    rows    = 10'd479;
    columns = 10'd0;
    tick();
    check_rgb("last_visible_row", 4'h0, 4'h0, 4'hF);

    rows       = 10'd480;
    columns    = 10'd0;
    code       = 8'h2D;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    check_key("commit_uses_old_pending", 2'd3);
    commit_frame();
    check_key("new_pending_next_frame", 2'd1);
    check_rgb("red_again", 4'hF, 4'h0, 4'h0);

    send(8'hF0);
    #3;
    rst_n = 1'b0;
    #1;
    check_rgb("async_reset_rgb", 4'h0, 4'h0, 4'h0);
    check_key("async_reset_key", 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'h32);
    commit_frame();
    check_key("make_after_reset", 2'd3);
    check_rgb("blue_after_reset", 4'h0, 4'h0, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_color_plotter.md
Name: key_color_plotter

Overview:
- Registered, parametrised successor to the combinational VGA plotter.
- Consumes PS/2 set-2 scancode bytes from the keyboard receiver and tracks make/break/extended sequences with a state machine.
- Holds the colour of the most recently pressed mapped key and commits colour changes only at the start of vertical blanking, so a frame never tears.
- Drives the RGB pins from the pixel counters supplied by the VGA sync generator.

Parameters:
- H_ACTIVE, 640, visible columns; columns >= H_ACTIVE is blanking.
- V_ACTIVE, 480, visible rows; rows >= V_ACTIVE is blanking.
- CNT_W, 10, width of the rows/columns inputs.
- COLOR_BITS, 4, bits per colour channel.
- KEY_R, 8'h2D, scancode selecting red.
- KEY_G, 8'h34, scancode selecting green.
- KEY_B, 8'h32, scancode selecting blue.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- rows  in  CNT_W  current pixel row from the sync generator.
- columns  in  CNT_W  current pixel column from the sync generator.
- code  in  8  scancode byte from the PS/2 receiver.
- code_valid  in  1  one-cycle strobe; code is valid only while high.
- data_red  out  COLOR_BITS  red channel, registered.
- data_green  out  COLOR_BITS  green channel, registered.
- data_blue  out  COLOR_BITS  blue channel, registered.
- active_key  out  2  committed selection: 0 none/white, 1 red, 2 green, 3 blue.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Decoder FSM goes to IDLE; pending and committed selection are 0.
  - data_* are all zeros; active_key is 0.
- Decoder FSM advances only on cycles with code_valid=1; with code_valid=0 it holds. States:
  - IDLE:
    - code 8'hF0 -> BRK.
    - code 8'hE0 -> EXT.
    - KEY_R/KEY_G/KEY_B -> pending set to 1/2/3 (make); stay IDLE.
    - any other code: ignored; stay IDLE.
  - BRK (break of a non-extended key):
    - If code equals the key of the current pending selection, pending becomes 0.
    - Otherwise pending is unchanged.
    - -> IDLE.
  - EXT:
    - code 8'hF0 -> EXT_BRK.
    - any other code -> IDLE; the extended key is ignored, pending unchanged.
  - EXT_BRK:
    - any code -> IDLE; ignored.
- Key precedence:
  - Last mapped make wins.
  - Typematic repeats of the held key re-write the same value; no effect.
  - Releasing a non-selected mapped key does not change pending.
- Commit:
  - committed <= pending on the single cycle where rows==V_ACTIVE and columns==0 (start of vertical blanking).
  - If pending is written on that same cycle, the committed value is the pending value from before that write; the new value commits at the next frame.
  - active_key reflects committed.
- Pixel output (one-cycle latency; output at cycle n+1 corresponds to rows/columns at cycle n):
  - rows>=V_ACTIVE or columns>=H_ACTIVE: all channels 0.
  - committed 0: all channels all-ones (white).
  - committed 1: red all-ones, others 0.
  - committed 2: green all-ones, others 0.
  - committed 3: blue all-ones, others 0.
- Blanking comparisons are unsigned at width CNT_W.
- Reset mid-sequence (e.g. in BRK) discards the partial sequence; the first byte after reset is decoded from IDLE.

Test Plan:
- Reset check: hold rst_n=0 with rows=0, columns=0 -> data_*=0, active_key=0. Release reset; one cycle later with committed 0 -> data_*=4'hF.
- Make red: code 8'h2D mid-frame (rows=100) -> active_key stays 0 until rows=480,columns=0. Then active_key=1; at next frame rows=0,columns=0 -> data_red=4'hF, green=0, blue=0 one cycle later.
- Break: 8'h2D then 8'hF0,8'h2D, then commit -> active_key=0, white pixels. Sequence 8'h34, 8'hF0,8'h2D -> active_key=2 after commit.
- Extended codes: 8'hE0,8'h34 then 8'hE0,8'hF0,8'h32 from reset -> active_key remains 0 after commit.
- Blanking and latency: committed=3; drive columns=639 then 640 on row 10 -> data_blue=4'hF then 0, each one cycle after its input. Row 480 -> all channels 0.
- Async reset mid-sequence: send 8'hF0, assert rst_n low between clock edges -> outputs go to 0 immediately. After release, 8'h32 plus commit -> active_key=3, i.e. the byte is decoded as a make, not a break.
